// File: rtl/draw_scheduler.sv
// Sequences the board-repaint and piece engines one at a time (erase old piece,
// then draw new) and multiplexes the active engine onto the single VGA write port.
module draw_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       board_req,
    input  logic       piece_req,
    input  logic [2:0] new_block,
    input  logic [1:0] new_rotation,
    input  logic [4:0] new_x,
    input  logic [5:0] new_y,
    output logic       board_en,
    input  logic [7:0] board_x,
    input  logic [6:0] board_y,
    input  logic [5:0] board_colour,
    input  logic       board_done,
    output logic       piece_en,
    output logic       piece_clear,
    output logic [2:0] piece_block,
    output logic [1:0] piece_rotation,
    output logic [4:0] piece_x,
    output logic [5:0] piece_y,
    input  logic [7:0] piece_vx,
    input  logic [6:0] piece_vy,
    input  logic [5:0] piece_colour,
    input  logic       piece_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [5:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BOARD = 3'd1,
        CLR   = 3'd2,
        GAP   = 3'd3,
        DRAW  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic       board_pend_r;
    logic       piece_pend_r;
    logic       old_valid_r;
    logic       piece_en_d_r;
    logic       start_board_s;
    logic       enter_draw_s;
    logic [2:0] new_block_r;
    logic [1:0] new_rotation_r;
    logic [4:0] new_x_r;
    logic [5:0] new_y_r;
    logic [2:0] old_block_r;
    logic [1:0] old_rotation_r;
    logic [4:0] old_x_r;
    logic [5:0] old_y_r;

    assign start_board_s = (state_r == IDLE) && (next_state_s == BOARD);
    assign enter_draw_s  = (state_r != DRAW) && (next_state_s == DRAW);
    assign busy          = (state_r != IDLE) | board_pend_r | piece_pend_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; a repaint already erased the old piece, so BOARD goes straight to DRAW
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (board_pend_r) begin
                    next_state_s = BOARD;
                end else if (piece_pend_r && old_valid_r) begin
                    next_state_s = CLR;
                end else if (piece_pend_r) begin
                    next_state_s = DRAW;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BOARD: begin
                if (board_done) begin
                    next_state_s = piece_pend_r ? DRAW : DONE;
                end else begin
                    next_state_s = BOARD;
                end
            end
            CLR:     next_state_s = piece_done ? GAP : CLR;
            GAP:     next_state_s = DRAW;
            DRAW:    next_state_s = piece_done ? DONE : DRAW;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Pending flags; a new request wins over the clear so it is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            board_pend_r <= 1'b0;
            piece_pend_r <= 1'b0;
        end else begin
            if (board_req) begin
                board_pend_r <= 1'b1;
            end else if (start_board_s) begin
                board_pend_r <= 1'b0;
            end
            if (piece_req) begin
                piece_pend_r <= 1'b1;
            end else if (enter_draw_s) begin
                piece_pend_r <= 1'b0;
            end
        end
    end

    // NEW piece parameters, last request wins
    always_ff @(posedge clk) begin
        if (reset) begin
            new_block_r    <= 3'd0;
            new_rotation_r <= 2'd0;
            new_x_r        <= 5'd0;
            new_y_r        <= 6'd0;
        end else if (piece_req) begin
            new_block_r    <= new_block;
            new_rotation_r <= new_rotation;
            new_x_r        <= new_x;
            new_y_r        <= new_y;
        end
    end

    // OLD piece parameters: the position currently on screen
    always_ff @(posedge clk) begin
        if (reset) begin
            old_valid_r    <= 1'b0;
            old_block_r    <= 3'd0;
            old_rotation_r <= 2'd0;
            old_x_r        <= 5'd0;
            old_y_r        <= 6'd0;
        end else if (enter_draw_s) begin
            old_valid_r    <= 1'b1;
            old_block_r    <= new_block_r;
            old_rotation_r <= new_rotation_r;
            old_x_r        <= new_x_r;
            old_y_r        <= new_y_r;
        end
    end

    // Piece enable delayed to match the engine's registered pixel output
    always_ff @(posedge clk) begin
        if (reset) begin
            piece_en_d_r <= 1'b0;
        end else begin
            piece_en_d_r <= piece_en;
        end
    end

    // Engine enables, piece parameters and VGA mux decoded from state
    always_comb begin
        board_en       = 1'b0;
        piece_en       = 1'b0;
        piece_clear    = 1'b0;
        piece_block    = 3'd0;
        piece_rotation = 2'd0;
        piece_x        = 5'd0;
        piece_y        = 6'd0;
        vga_x          = 8'd0;
        vga_y          = 7'd0;
        vga_colour     = 6'd0;
        plot           = 1'b0;
        frame_done     = 1'b0;
        case (state_r)
            BOARD: begin
                board_en   = 1'b1;
                plot       = ~board_done;
                vga_x      = board_x;
                vga_y      = board_y;
                vga_colour = board_colour;
            end
            CLR: begin
                piece_en       = 1'b1;
                piece_clear    = 1'b1;
                piece_block    = old_block_r;
                piece_rotation = old_rotation_r;
                piece_x        = old_x_r;
                piece_y        = old_y_r;
                plot           = piece_en_d_r & ~piece_done;
                vga_x          = piece_vx;
                vga_y          = piece_vy;
                vga_colour     = piece_colour;
            end
            DRAW: begin
                piece_en       = 1'b1;
                piece_block    = new_block_r;
                piece_rotation = new_rotation_r;
                piece_x        = new_x_r;
                piece_y        = new_y_r;
                plot           = piece_en_d_r & ~piece_done;
                vga_x          = piece_vx;
                vga_y          = piece_vy;
                vga_colour     = piece_colour;
            end
            DONE:    frame_done = 1'b1;
            default: plot = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: behavioural engine models, a pixel/frame scoreboard
// checked by a monitor, and directed request sequences.
module tb_draw_scheduler;

    localparam int BOARD_PIXELS = 3840;
    localparam int PIECE_PIXELS = 64;
    localparam int BUDGET       = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       board_req = 1'b0;
    logic       piece_req = 1'b0;
    logic [2:0] new_block = 3'd0;
    logic [1:0] new_rotation = 2'd0;
    logic [4:0] new_x = 5'd0;
    logic [5:0] new_y = 6'd0;
    logic       board_en, piece_en, piece_clear, plot, busy, frame_done;
    logic [7:0] board_x, piece_vx, vga_x;
    logic [6:0] board_y, piece_vy, vga_y;
    logic [5:0] board_colour, piece_colour, vga_colour, piece_y;
    logic       board_done, piece_done;
    logic [2:0] piece_block;
    logic [1:0] piece_rotation;
    logic [4:0] piece_x;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [5:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   exp_frames[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   frame_plots = 0;

    always #5 clk = ~clk;

    draw_scheduler dut (
        .clk(clk), .reset(reset), .board_req(board_req), .piece_req(piece_req),
        .new_block(new_block), .new_rotation(new_rotation), .new_x(new_x), .new_y(new_y),
        .board_en(board_en), .board_x(board_x), .board_y(board_y),
        .board_colour(board_colour), .board_done(board_done),
        .piece_en(piece_en), .piece_clear(piece_clear), .piece_block(piece_block),
        .piece_rotation(piece_rotation), .piece_x(piece_x), .piece_y(piece_y),
        .piece_vx(piece_vx), .piece_vy(piece_vy), .piece_colour(piece_colour),
        .piece_done(piece_done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .frame_done(frame_done)
    );

    // Board engine model: one pixel per cycle, combinational done after the last one
    logic [12:0] bcnt;
    always @(posedge clk) begin
        if (reset || !board_en) bcnt <= 13'd0;
        else if (bcnt < 13'(BOARD_PIXELS)) bcnt <= bcnt + 13'd1;
    end
    assign board_done   = board_en && (bcnt == 13'(BOARD_PIXELS));
    assign board_x      = 8'(bcnt % 13'd40);
    assign board_y      = 7'(bcnt / 13'd40);
    assign board_colour = bcnt[5:0];

    // Piece engine model: registered pixels, registered done pulse after 64 pixels
    logic [6:0] pcnt;
    always @(posedge clk) begin
        if (reset || !piece_en) begin
            pcnt <= 7'd0; piece_done <= 1'b0;
            piece_vx <= 8'd0; piece_vy <= 7'd0; piece_colour <= 6'd0;
        end else if (pcnt < 7'(PIECE_PIXELS)) begin
            piece_vx     <= {piece_x, pcnt[2:0]};
            piece_vy     <= {piece_y[3:0], pcnt[5:3]};
            piece_colour <= piece_clear ? 6'd0 : {piece_block, piece_rotation, 1'b1};
            pcnt         <= pcnt + 7'd1;
            piece_done   <= 1'b0;
        end else if (pcnt == 7'(PIECE_PIXELS)) begin
            piece_done <= 1'b1;
            pcnt       <= pcnt + 7'd1;
        end else begin
            piece_done <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_board();
        for (int c = 0; c < BOARD_PIXELS; c++) begin
            logic [12:0] cc;
            cc = 13'(c);
            exp_q.push_back({8'(cc % 13'd40), 7'(cc / 13'd40), cc[5:0]});
        end
    endtask

    task automatic push_piece(input logic clr, input logic [2:0] b, input logic [1:0] r,
                              input logic [4:0] x, input logic [5:0] y);
        for (int k = 0; k < PIECE_PIXELS; k++) begin
            logic [5:0] kk;
            kk = 6'(k);
            exp_q.push_back({{x, kk[2:0]}, {y[3:0], kk[5:3]}, clr ? 6'd0 : {b, r, 1'b1}});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_piece(input logic [2:0] b, input logic [1:0] r,
                               input logic [4:0] x, input logic [5:0] y, input logic brd);
        piece_req = 1'b1; board_req = brd;
        new_block = b; new_rotation = r; new_x = x; new_y = y;
        tick();
        piece_req = 1'b0; board_req = 1'b0;
    endtask

    task automatic pulse_board();
        board_req = 1'b1;
        tick();
        board_req = 1'b0;
    endtask

    // Runs from a sampled enable cycle to frame_done, recording what the sequence looked like
    task automatic run_frame(output int n, output int gaps, output bit saw_clr, output bit prev_bd);
        n = 0; gaps = 0; saw_clr = 1'b0; prev_bd = 1'b0;
        while (!frame_done && n < BUDGET) begin
            if (piece_clear) saw_clr = 1'b1;
            if (!piece_en && !board_en) gaps++;
            prev_bd = board_done;
            tick();
            n++;
        end
        check("frame_done_reached", {31'd0, frame_done}, 32'd1);
        tick();
        check("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    endtask

    // Monitor: every plot pops one expected pixel, every frame_done pops one plot count
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                frame_plots = 0;
            end else begin
                check("enable_overlap", {31'd0, board_en & piece_en}, 32'd0);
                if (plot) begin
                    frame_plots++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_plot", 32'd1, 32'd0);
                    end else begin
                        pix_t e;
                        e = exp_q.pop_front();
                        n_cmp++;
                        if ({vga_x, vga_y, vga_colour} !== e) begin
                            n_fail++;
                            $display("FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                                     vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                        end
                    end
                end
                if (frame_done) begin
                    if (exp_frames.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        check("frame_plots", 32'(frame_plots), 32'(exp_frames.pop_front()));
                    end
                    frame_plots = 0;
                end
            end
        end
    end

    initial begin
        int  n, gaps;
        bit  saw_clr, prev_bd;

        repeat (3) tick();
        reset = 1'b0;
        check("reset_outputs",
              {8'd0, board_en, piece_en, piece_clear, piece_block, piece_rotation, piece_x,
               piece_y, plot, busy, frame_done}, 32'd0);
        check("reset_vga", {11'd0, vga_x, vga_y, vga_colour}, 32'd0);

        // First piece: no previous position, so no clear pass
        push_piece(1'b0, 3'd3, 2'd1, 5'd4, 6'd2);
        exp_frames.push_back(64);
        pulse_piece(3'd3, 2'd1, 5'd4, 6'd2, 1'b0);
        check("p1_en_t1", {31'd0, piece_en}, 32'd0);
        check("p1_busy_t1", {31'd0, busy}, 32'd1);
        tick();
        check("p1_en_t2", {30'd0, piece_en, piece_clear}, 32'd2);
        run_frame(n, gaps, saw_clr, prev_bd);
        check("p1_cycles", 32'(n), 32'd66);
        check("p1_no_clr", {31'd0, saw_clr}, 32'd0);
        check("p1_idle", {31'd0, busy}, 32'd0);
        tick();

        // Second piece: erase at (3,1,4,2), one gap cycle, draw at x=5
        push_piece(1'b1, 3'd3, 2'd1, 5'd4, 6'd2);
        push_piece(1'b0, 3'd3, 2'd1, 5'd5, 6'd2);
        exp_frames.push_back(128);
        pulse_piece(3'd3, 2'd1, 5'd5, 6'd2, 1'b0);
        tick();
        check("p2_clr_en", {30'd0, piece_en, piece_clear}, 32'd3);
        check("p2_old_regs", {16'd0, piece_block, piece_rotation, piece_x, piece_y},
              {16'd0, 3'd3, 2'd1, 5'd4, 6'd2});
        run_frame(n, gaps, saw_clr, prev_bd);
        check("p2_cycles", 32'(n), 32'd133);
        check("p2_gap", 32'(gaps), 32'd1);
        tick();

        // Board repaint alone
        push_board();
        exp_frames.push_back(3840);
        pulse_board();
        tick();
        check("b_en", {30'd0, board_en, piece_en}, 32'd2);
        run_frame(n, gaps, saw_clr, prev_bd);
        check("b_cycles", 32'(n), 32'd3841);
        check("b_done_before_frame", {31'd0, prev_bd}, 32'd1);
        tick();

        // Simultaneous board and piece requests: BOARD then DRAW, no clear
        push_board();
        push_piece(1'b0, 3'd5, 2'd2, 5'd6, 6'd8);
        exp_frames.push_back(3904);
        pulse_piece(3'd5, 2'd2, 5'd6, 6'd8, 1'b1);
        tick();
        check("bp_en", {30'd0, board_en, piece_en}, 32'd2);
        run_frame(n, gaps, saw_clr, prev_bd);
        check("bp_cycles", 32'(n), 32'd3907);
        check("bp_no_clr", {31'd0, saw_clr}, 32'd0);
        check("bp_no_gap", 32'(gaps), 32'd0);
        tick();

        // Two piece requests during BOARD: a single DRAW with the last one (x=7)
        push_board();
        push_piece(1'b0, 3'd1, 2'd0, 5'd7, 6'd3);
        exp_frames.push_back(3904);
        pulse_board();
        tick();
        pulse_piece(3'd1, 2'd0, 5'd1, 6'd3, 1'b0);
        tick();
        tick();
        pulse_piece(3'd1, 2'd0, 5'd7, 6'd3, 1'b0);
        run_frame(n, gaps, saw_clr, prev_bd);
        check("bpp_no_clr", {31'd0, saw_clr}, 32'd0);
        repeat (3) tick();
        check("bpp_single_draw", {31'd0, busy}, 32'd0);

        // Reset 100 cycles into BOARD drops the pass and forgets the old piece
        push_board();
        exp_frames.push_back(3840);
        pulse_board();
        tick();
        check("r_board_en", {31'd0, board_en}, 32'd1);
        repeat (99) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        exp_frames.delete();
        check("r_after", {29'd0, board_en, plot, busy}, 32'd0);
        reset = 1'b0;
        tick();
        push_piece(1'b0, 3'd2, 2'd3, 5'd9, 6'd10);
        exp_frames.push_back(64);
        pulse_piece(3'd2, 2'd3, 5'd9, 6'd10, 1'b0);
        tick();
        check("r_piece_skips_clr", {30'd0, piece_en, piece_clear}, 32'd2);
        run_frame(n, gaps, saw_clr, prev_bd);
        check("r_piece_cycles", 32'(n), 32'd66);
        check("r_piece_no_clr", {31'd0, saw_clr}, 32'd0);
        repeat (2) tick();

        check("pixels_left", 32'(exp_q.size()), 32'd0);
        check("frames_left", 32'(exp_frames.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Sequences and arbitrates the two VGA drawing engines: the board repaint engine (`draw_ram`) and the piece engine (`draw_tetromino`). It accepts board-repaint and piece-move requests from game control and runs the engines one at a time. When a piece moves, it first erases the piece's previous position and then draws the new position. It multiplexes the active engine's pixel stream onto the single VGA write port.

## Interface
Parameters
- BOARD_PIXELS, 3840, plots per board pass (10×24 blocks × 16 px); bench reference only.
- PIECE_PIXELS, 64, plots per piece pass (4 blocks × 16 px); bench reference only.

Ports
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high; one clock; sampled on rising clk.
- board_req  in  1  one-cycle pulse: repaint whole board.
- piece_req  in  1  one-cycle pulse: draw piece at new_* params.
- new_block  in  3  piece type, captured with piece_req.
- new_rotation  in  2  rotation, captured with piece_req.
- new_x  in  5  board column, captured with piece_req.
- new_y  in  6  board row, captured with piece_req.
- board_en  out  1  board engine run; low resets the engine.
- board_x  in  8  board engine pixel X; valid in the same cycle.
- board_y  in  7  board engine pixel Y.
- board_colour  in  6  board engine colour.
- board_done  in  1  board engine complete (combinational).
- piece_en  out  1  piece engine run; low resets the engine.
- piece_clear  out  1  piece engine draws colour 0.
- piece_block  out  3  piece engine block select.
- piece_rotation  out  2  piece engine rotation.
- piece_x  out  5  piece engine board column.
- piece_y  out  6  piece engine board row.
- piece_vx  in  8  piece engine pixel X; registered, 1-cycle latency.
- piece_vy  in  7  piece engine pixel Y.
- piece_colour  in  6  piece engine colour.
- piece_done  in  1  piece engine complete (registered pulse).
- vga_x  out  8  muxed pixel X.
- vga_y  out  7  muxed pixel Y.
- vga_colour  out  6  muxed colour.
- plot  out  1  VGA write enable.
- busy  out  1  state ≠ IDLE, or any request pending.
- frame_done  out  1  one-cycle pulse when a full sequence ends.

## Operation
- State machine states: IDLE, BOARD, CLR, GAP, DRAW, DONE. Reset forces IDLE.
- Pending flags:
  - board_pend is set by board_req.
  - piece_pend is set by piece_req, which also loads new_* into the NEW registers. If piece_req repeats while pending, the last value wins.
  - A flag is cleared when its pass starts.
- OLD registers plus old_valid:
  - Loaded from NEW on entry to DRAW; old_valid is set to 1 at that point.
  - Reset clears old_valid and all pending flags.
- IDLE transitions:
  - board_pend → BOARD.
  - Otherwise, piece_pend with old_valid → CLR.
  - Otherwise, piece_pend without old_valid → DRAW.
- BOARD:
  - board_en = 1.
  - On board_done: piece_pend → DRAW (no CLR, because the repaint has already erased the old piece); otherwise → DONE.
- CLR:
  - piece_en = 1, piece_clear = 1, piece_* = OLD.
  - On piece_done → GAP.
- GAP: one cycle with piece_en = 0, so the engine restarts from zero. Then → DRAW.
- DRAW:
  - piece_en = 1, piece_clear = 0, piece_* = NEW.
  - On piece_done → DONE.
- DONE:
  - frame_done = 1 for one cycle.
  - Then → IDLE, which immediately services any request that arrived during the sequence.
- board_en and piece_en decode combinationally from the state register. They are never both high.
- Plot and mux:
  - In BOARD: plot = ~board_done; vga_* = board_*.
  - In CLR or DRAW: plot = piece_en_d & ~piece_done, where piece_en_d is piece_en registered one cycle; vga_* = piece_*.
  - In all other states: plot = 0 and vga_* = 0.
- Requests arriving in any non-IDLE state only set pending flags. They never abort the active pass.
- Simultaneous board_req and piece_req are both latched and run as BOARD → DRAW.

## Timing
- Reset values: every output is 0; the state is IDLE; pending flags and old_valid are 0.
- Request to first enable: board_req/piece_req at cycle t gives an engine enable at t+2 (flag set at t+1, state change at t+2).
- Board pass: 3840 plot cycles, starting in the first BOARD cycle, then one cycle with board_done.
- Piece pass:
  - Entry cycle: no plot (pipeline fill).
  - Next 64 cycles: plot.
  - Then one cycle with piece_done, for 66 cycles in CLR or DRAW.
- CLR → DRAW adds exactly one GAP cycle.
- frame_done is asserted on the cycle after the final done.
- Reset mid-pass: the next cycle shows IDLE, enables low and plot 0. The interrupted pass is dropped, not resumed.

## Test plan
- Reset, then piece_req with block 3, rot 1, x 4, y 2:
  - No CLR state is entered.
  - Exactly 64 plots with piece_clear = 0.
  - frame_done is pulsed once.
  - OLD registers hold (3, 1, 4, 2).
- Second piece_req with x 5:
  - 64 plots with piece_clear = 1 at the old coordinates.
  - piece_en low for 1 cycle.
  - 64 plots with x = 5.
  - 133 cycles from first enable to frame_done.
- board_req alone: exactly 3840 plots, board_en never overlaps piece_en, frame_done 1 cycle after board_done.
- board_req and piece_req in the same cycle: BOARD (3840 plots) followed directly by DRAW (64 plots), with no clear pass.
- piece_req pulsed twice during BOARD (x = 1, then x = 7): one DRAW pass only, using x = 7.
- reset asserted 100 cycles into BOARD:
  - The next cycle shows board_en = 0, plot = 0, busy = 0.
  - A following piece_req skips CLR.
